// File: rtl/core_encode_pkg.sv
// core_encode_pkg
//   Shared definitions for the instruction encoder:
//   - enc_op_e    : operation IDs 0..53 accepted on IN_OP (54..63 are invalid)
//   - enc_fmt_e   : instruction format selected per operation
//   - opcode / funct3 / funct7 field constants (RV32I, RV32F subset, custom)
//   - immediate range limits and a signed range-check helper
//   - enc_entry_t : one buffered result (encoded word + error flag)
package core_encode_pkg;

  typedef enum logic [5:0] {
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_JALR, OP_JAL, OP_AUIPC, OP_LUI,
    OP_FLW, OP_FSW, OP_FADDS, OP_FSUBS, OP_FMULS, OP_FDIVS, OP_FEQS, OP_FLTS,
    OP_FLES, OP_FMVSX, OP_FCVTSW, OP_FCVTWS, OP_FSQRTS, OP_FSGNJXS,
    OP_IN, OP_OUT, OP_ROT
  } enc_op_e;

  // FMT_R1: R-type with the rs2 field forced to zero (unary FP ops).
  // FMT_SH: I-type shift, shamt in [24:20] and funct7 in [31:25].
  typedef enum logic [2:0] {
    FMT_R, FMT_R1, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } enc_fmt_e;

  // Major opcodes
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_ROT      = 7'b0001011;
  localparam logic [6:0] OPC_IO       = 7'b0000001;

  // Integer ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load/store width funct3
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  // OP-FP funct3
  localparam logic [2:0] F3_FEQ    = 3'b010;
  localparam logic [2:0] F3_FLT    = 3'b001;
  localparam logic [2:0] F3_FLE    = 3'b000;
  localparam logic [2:0] F3_FSGNJX = 3'b010;
  localparam logic [2:0] F3_FDEF   = 3'b000;

  // Custom I/O funct3
  localparam logic [2:0] F3_IO_IN  = 3'b000;
  localparam logic [2:0] F3_IO_OUT = 3'b001;

  // funct7
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_FADD   = 7'b0000000;
  localparam logic [6:0] F7_FSUB   = 7'b0000100;
  localparam logic [6:0] F7_FMUL   = 7'b0001000;
  localparam logic [6:0] F7_FDIV   = 7'b0001100;
  localparam logic [6:0] F7_FSGNJ  = 7'b0010000;
  localparam logic [6:0] F7_FCMP   = 7'b1010000;
  localparam logic [6:0] F7_FMVSX  = 7'b1111000;
  localparam logic [6:0] F7_FCVTSW = 7'b1101000;
  localparam logic [6:0] F7_FCVTWS = 7'b1100000;
  localparam logic [6:0] F7_FSQRT  = 7'b0101100;

  // Immediate limits (byte offsets, signed)
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_entry_t;

  function automatic logic imm_out_of_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) < lo) || ($signed(imm) > hi);
  endfunction

endpackage

// File: rtl/core_encode_pack.sv
// core_encode_pack
//   Purely combinational instruction word builder.
//   op   : operation ID (enc_op_e, values 54..63 invalid)
//   rd/rs1/rs2 : register numbers, placed only where the format has them
//   imm  : decoder-style immediate (sign-extended byte offset, or U value)
//   inst : encoded 32-bit instruction word
//   err  : invalid op or immediate out of range for the format
module core_encode_pack
  import core_encode_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  enc_op_e    op_e;
  enc_fmt_e   fmt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       op_ok;

  assign op_e = enc_op_e'(op);

  // Per-operation field lookup
  always_comb begin
    fmt   = FMT_R;
    opc   = OPC_OP;
    f3    = '0;
    f7    = F7_BASE;
    op_ok = 1'b1;
    case (op_e)
      OP_ADDI:    begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_ADD;  end
      OP_SLTI:    begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLT;  end
      OP_SLTIU:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLTU; end
      OP_XORI:    begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_XOR;  end
      OP_ORI:     begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_OR;   end
      OP_ANDI:    begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_AND;  end
      OP_SLLI:    begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SLL;  end
      OP_SRLI:    begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;   end
      OP_SRAI:    begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;   f7 = F7_ALT; end
      OP_ADD:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;  end
      OP_SUB:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;  f7 = F7_ALT; end
      OP_SLL:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLL;  end
      OP_SLT:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLT;  end
      OP_SLTU:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLTU; end
      OP_XOR:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_XOR;  end
      OP_SRL:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;   end
      OP_SRA:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;   f7 = F7_ALT; end
      OP_OR:      begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_OR;   end
      OP_AND:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_AND;  end
      OP_BEQ:     begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BEQ;  end
      OP_BNE:     begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BNE;  end
      OP_BLT:     begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLT;  end
      OP_BGE:     begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGE;  end
      OP_BLTU:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLTU; end
      OP_BGEU:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGEU; end
      OP_LB:      begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_B;    end
      OP_LH:      begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_H;    end
      OP_LW:      begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_W;    end
      OP_LBU:     begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_BU;   end
      OP_LHU:     begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_HU;   end
      OP_SB:      begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_B;    end
      OP_SH:      begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_H;    end
      OP_SW:      begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_W;    end
      OP_JALR:    begin fmt = FMT_I;  opc = OPC_JALR;   f3 = F3_ADD;  end
      OP_JAL:     begin fmt = FMT_J;  opc = OPC_JAL;    end
      OP_AUIPC:   begin fmt = FMT_U;  opc = OPC_AUIPC;  end
      OP_LUI:     begin fmt = FMT_U;  opc = OPC_LUI;    end
      OP_FLW:     begin fmt = FMT_I;  opc = OPC_LOAD_FP;  f3 = F3_W;  end
      OP_FSW:     begin fmt = FMT_S;  opc = OPC_STORE_FP; f3 = F3_W;  end
      OP_FADDS:   begin fmt = FMT_R;  opc = OPC_OP_FP; f3 = F3_FDEF;   f7 = F7_FADD;   end
      OP_FSUBS:   begin fmt = FMT_R;  opc = OPC_OP_FP; f3 = F3_FDEF;   f7 = F7_FSUB;   end
      OP_FMULS:   begin fmt = FMT_R;  opc = OPC_OP_FP; f3 = F3_FDEF;   f7 = F7_FMUL;   end
      OP_FDIVS:   begin fmt = FMT_R;  opc = OPC_OP_FP; f3 = F3_FDEF;   f7 = F7_FDIV;   end
      OP_FEQS:    begin fmt = FMT_R;  opc = OPC_OP_FP; f3 = F3_FEQ;    f7 = F7_FCMP;   end
      OP_FLTS:    begin fmt = FMT_R;  opc = OPC_OP_FP; f3 = F3_FLT;    f7 = F7_FCMP;   end
      OP_FLES:    begin fmt = FMT_R;  opc = OPC_OP_FP; f3 = F3_FLE;    f7 = F7_FCMP;   end
      OP_FMVSX:   begin fmt = FMT_R1; opc = OPC_OP_FP; f3 = F3_FDEF;   f7 = F7_FMVSX;  end
      OP_FCVTSW:  begin fmt = FMT_R1; opc = OPC_OP_FP; f3 = F3_FDEF;   f7 = F7_FCVTSW; end
      OP_FCVTWS:  begin fmt = FMT_R1; opc = OPC_OP_FP; f3 = F3_FDEF;   f7 = F7_FCVTWS; end
      OP_FSQRTS:  begin fmt = FMT_R1; opc = OPC_OP_FP; f3 = F3_FDEF;   f7 = F7_FSQRT;  end
      OP_FSGNJXS: begin fmt = FMT_R;  opc = OPC_OP_FP; f3 = F3_FSGNJX; f7 = F7_FSGNJ;  end
      OP_IN:      begin fmt = FMT_I;  opc = OPC_IO;  f3 = F3_IO_IN;  end
      OP_OUT:     begin fmt = FMT_I;  opc = OPC_IO;  f3 = F3_IO_OUT; end
      OP_ROT:     begin fmt = FMT_R;  opc = OPC_ROT; end
      default:    op_ok = 1'b0;
    endcase
  end

  // Field assembly and range checking; out-of-range immediates still
  // encode from the truncated bits so the consumer sees a best-effort word.
  always_comb begin
    inst = NOP_INST;
    err  = 1'b1;
    if (op_ok) begin
      err = 1'b0;
      case (fmt)
        FMT_R:  inst = {f7, rs2, rs1, f3, rd, opc};
        FMT_R1: inst = {f7, 5'd0, rs1, f3, rd, opc};
        FMT_I: begin
          inst = {imm[11:0], rs1, f3, rd, opc};
          err  = imm_out_of_range(imm, IMM12_MIN, IMM12_MAX);
        end
        FMT_SH: begin
          inst = {f7, imm[4:0], rs1, f3, rd, opc};
          err  = (imm[31:5] != '0);
        end
        FMT_S: begin
          inst = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
          err  = imm_out_of_range(imm, IMM12_MIN, IMM12_MAX);
        end
        FMT_B: begin
          inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
          err  = imm_out_of_range(imm, IMMB_MIN, IMMB_MAX) || imm[0];
        end
        FMT_U: begin
          inst = {imm[31:12], rd, opc};
          err  = (imm[11:0] != '0);
        end
        FMT_J: begin
          inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
          err  = imm_out_of_range(imm, IMMJ_MIN, IMMJ_MAX) || imm[0];
        end
        default: inst = NOP_INST;
      endcase
    end
  end

endmodule

// File: rtl/core_encode.sv
// core_encode
//   Registered instruction encoder with a 2-entry in-order result FIFO.
//   CLK, RST_N            : clock, synchronous active-low reset
//   IN_VALID / IN_READY   : request handshake (accept on both high)
//   IN_OP, IN_RD, IN_RS1, IN_RS2, IN_IMM : operation and operands
//   OUT_VALID / OUT_READY : result handshake (pop on both high)
//   OUT_INST, OUT_ERR     : head entry word and error flag
//   ENC_COUNT             : wrapping count of popped words
module core_encode
  import core_encode_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [5:0]  IN_OP,
  input  logic [4:0]  IN_RD,
  input  logic [4:0]  IN_RS1,
  input  logic [4:0]  IN_RS2,
  input  logic [31:0] IN_IMM,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_INST,
  output logic        OUT_ERR,
  output logic [15:0] ENC_COUNT
);

  enc_entry_t  fifo_q [2];
  enc_entry_t  head;
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  occ_q;
  logic [1:0]  occ_next;
  logic        ready_q;
  logic [15:0] count_q;
  logic        push;
  logic        pop;
  logic [31:0] pack_inst;
  logic        pack_err;

  core_encode_pack u_pack (
    .op   (IN_OP),
    .rd   (IN_RD),
    .rs1  (IN_RS1),
    .rs2  (IN_RS2),
    .imm  (IN_IMM),
    .inst (pack_inst),
    .err  (pack_err)
  );

  assign push = IN_VALID && ready_q;
  assign pop  = (occ_q != 2'd0) && OUT_READY;

  always_comb begin
    occ_next = occ_q;
    case ({push, pop})
      2'b10:   occ_next = occ_q + 2'd1;
      2'b01:   occ_next = occ_q - 2'd1;
      default: occ_next = occ_q;
    endcase
  end

  // ready_q tracks (occupancy < 2) one edge ahead so IN_READY is a plain
  // flop: 0 while in reset, 1 after the first edge with RST_N high, and
  // never combinationally dependent on OUT_READY.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
      ready_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{inst: pack_inst, err: pack_err};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        count_q  <= count_q + 16'd1;
      end
      occ_q   <= occ_next;
      ready_q <= (occ_next < 2'd2);
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign IN_READY  = ready_q;
  assign OUT_VALID = (occ_q != 2'd0);
  assign OUT_INST  = head.inst;
  assign OUT_ERR   = head.err;
  assign ENC_COUNT = count_q;

endmodule

// File: doc/core_encode.md
CORE_ENCODE -- requirements
Module: core_encode

Interface
REQ-001 SHALL: CLK  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: RST_N  input  1  reset, synchronous, active-low.
REQ-003 SHALL: IN_VALID  input  1  encode request valid.
REQ-004 SHALL: IN_READY  output  1  request accepted when IN_VALID && IN_READY.
REQ-005 SHALL: IN_OP  input  6  operation ID, per the package enum (REQ-036).
REQ-006 SHALL: IN_RD / IN_RS1 / IN_RS2  input  5 each  register numbers, integer or FP per op.
REQ-007 SHALL: IN_IMM  input  32  immediate, in the same form the decoder emits as IMM:
  - I/S/B/J: sign-extended byte offset.
  - U: upper value with low 12 bits zero.
REQ-008 SHALL: OUT_VALID  output  1  encoded word available.
REQ-009 SHALL: OUT_READY  input  1  consumer pops on OUT_VALID && OUT_READY.
REQ-010 SHALL: OUT_INST  output  32  encoded instruction word.
REQ-011 SHALL: OUT_ERR  output  1  the head entry had an invalid op or an out-of-range immediate.
REQ-012 SHALL: ENC_COUNT  output  16  count of words popped, wrapping.

Function
REQ-013 SHALL: Encoding is registered: a word accepted in cycle N is visible at the output in cycle N+1 at the earliest.
REQ-014 SHALL: Results are held in a 2-entry in-order FIFO.
REQ-015 SHALL: IN_READY = (occupancy < 2), a function of registered occupancy only; it has no combinational path from OUT_READY.
REQ-016 SHALL: OUT_VALID = (occupancy > 0).
REQ-017 SHALL: OUT_INST and OUT_ERR show the head entry and stay stable while OUT_VALID && !OUT_READY.
REQ-018 SHALL: Push and pop in the same cycle leave occupancy unchanged.
REQ-019 SHALL: Write and read pointers are 1 bit each and wrap 1->0.
REQ-020 SHALL: Integer opcodes:
  - OP 0010011, OP_REG 0110011, BRANCH 1100011, LOAD 0000011, STORE 0100011.
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 (funct3 000).
REQ-021 SHALL: Integer funct3 values are standard RV32I.
  - SRAI and SUB/SRA set funct7 0100000; all other integer ops set funct7 0000000.
REQ-022 SHALL: FP ops:
  - FLW uses opcode 0000111, funct3 010; FSW uses opcode 0100111, funct3 010.
  - OP-FP ops use opcode 1010011 with funct7: FADD 0000000, FSUB 0000100, FMUL 0001000, FDIV 0001100, FSGNJX 0010000, FEQ/FLT/FLE 1010000, FMVSX 1111000, FCVTSW 1101000, FCVTWS 1100000, FSQRT 0101100.
REQ-023 SHALL: OP-FP funct3 values: FEQ 010, FLT 001, FLE 000, FSGNJX 010, all others 000.
  - rs2 field is forced to 0 for FMVSX, FCVTSW, FCVTWS and FSQRT.
REQ-024 SHALL: Custom ops:
  - ROT: opcode 0001011, R-type, funct3/funct7 zero.
  - IN: opcode 0000001, funct3 000, I-type.
  - OUT: opcode 0000001, funct3 001, I-type.
REQ-025 SHALL: Unused register fields of a format are driven 0.
REQ-026 SHALL: Immediate placement:
  - I-type: imm[11:0] -> [31:20].
  - S-type: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
  - B-type: imm[12|10:5] -> [31:25], imm[4:1|11] -> [11:7].
  - U-type: imm[31:12] -> [31:12].
  - J-type: imm[20|10:1|11|19:12] -> [31:12].
  - Shift-immediates: shamt = imm[4:0] -> [24:20].
REQ-027 SHALL: Immediate range checks, each setting OUT_ERR=1:
  - I/S: signed value outside -2048..2047.
  - B: outside -4096..4094, or imm[0]=1.
  - J: outside -1048576..1048574, or imm[0]=1.
  - U: imm[11:0]!=0.
  - Shift: imm[31:5]!=0.
REQ-028 SHALL: On a range error the word is still encoded from the truncated fields.
REQ-029 SHALL: IN_OP values 54..63 encode as 0x00000013 (NOP) with OUT_ERR=1.
REQ-030 SHALL: ENC_COUNT increments by 1 per pop and wraps 0xFFFF->0x0000.

Reset
REQ-031 SHALL: With RST_N=0 at a clock edge:
  - occupancy and both pointers become 0.
  - OUT_VALID=0, OUT_INST=0, OUT_ERR=0, ENC_COUNT=0.
REQ-032 SHALL: IN_READY reads 0 during reset and 1 in the first cycle after reset release.
REQ-033 SHALL: Reset mid-operation discards buffered entries; no partial pop is counted.

Structure
REQ-034 SHALL: A shared package core_encode_pkg holds the op enum, the opcode/funct3/funct7 constants and the immediate range constants.
REQ-035 SHALL: The combinational word builder is one sub-module, core_encode_pack, with inputs op/regs/imm and outputs inst/err; FIFO, handshake and counter logic live in core_encode.
REQ-036 SHALL: The enum assigns values 0..53 in this order:
  - ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
  - ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  - BEQ BNE BLT BGE BLTU BGEU.
  - LB LH LW LBU LHU SB SH SW.
  - JALR JAL AUIPC LUI.
  - FLW FSW FADDS FSUBS FMULS FDIVS FEQS FLTS FLES FMVSX FCVTSW FCVTWS FSQRTS FSGNJXS.
  - IN OUT ROT.

Verification
REQ-037 SHALL: ADDI rd=1 rs1=2 imm=-1 -> OUT_INST=0xFFF10093, OUT_ERR=0, one cycle after acceptance.
REQ-038 SHALL: ADD rd=3 rs1=1 rs2=2 -> 0x002081B3; BEQ rs1=1 rs2=2 imm=8 -> 0x00208463.
REQ-039 SHALL: LUI rd=5 imm=0x12345000 -> 0x123452B7, OUT_ERR=0; LUI imm=0x12345001 -> OUT_ERR=1.
REQ-040 SHALL: JAL imm=3 -> OUT_ERR=1; IN_OP=60 -> 0x00000013 with OUT_ERR=1.
REQ-041 SHALL: OUT_READY=0 with 3 back-to-back requests -> IN_READY=0 after 2 pushes, third held; then OUT_READY=1 -> 3 words pop in order, ENC_COUNT=3.
REQ-042 SHALL: ENC_COUNT preset near wrap (0xFFFF) plus one pop -> 0x0000; RST_N=0 with 2 entries buffered -> OUT_VALID=0 and ENC_COUNT=0 on the next cycle.
